// File: rtl/sysid_info_regs.sv
// Eight-word Avalon-MM system ID / info register file with fixed 1-cycle read latency.
// Define SYSID_UPTIME_EN to build the cycle counter, seconds counter and control/status word.
module sysid_info_regs #(
  parameter logic [31:0] SYSTEM_ID     = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP     = 32'h0000_0000,
  parameter logic [15:0] VERSION       = 16'h0001,
  parameter int unsigned CLK_FREQ_HZ   = 50000000,
  parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  logic [31:0] scratch_q, scratch_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q;
  logic [31:0] word4, word5, word6, word7;
  logic        uptime_present;

  assign scratch_d = (write && address == 3'd3) ? writedata : scratch_q;

`ifdef SYSID_UPTIME_EN
  localparam int unsigned PreW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PreW-1:0] PreTerm = PreW'(CLK_FREQ_HZ - 1);

  logic [63:0]     cycle_cnt_q, cycle_cnt_d;
  logic [31:0]     shadow_q, shadow_d;
  logic [31:0]     sec_q, sec_d;
  logic [PreW-1:0] pre_q, pre_d;
  logic            freeze_q, freeze_d;
  logic            wrap_q, wrap_d;
  logic            wrap_set;
  logic            wr_ctrl;

  assign wr_ctrl = write && (address == 3'd6);

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    shadow_d    = shadow_q;
    sec_d       = sec_q;
    pre_d       = pre_q;
    freeze_d    = freeze_q;
    wrap_d      = wrap_q;
    wrap_set    = !freeze_q && (&cycle_cnt_q);
    if (!freeze_q) begin
      cycle_cnt_d = cycle_cnt_q + 64'd1;
      if (pre_q == PreTerm) begin
        pre_d = '0;
        sec_d = sec_q + 32'd1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
    if (wr_ctrl) begin
      freeze_d = writedata[1];
      if (writedata[2]) wrap_d = 1'b0;
      // Clear overrides the increment computed above.
      if (writedata[0]) begin
        cycle_cnt_d = '0;
        pre_d       = '0;
        sec_d       = '0;
      end
    end
    // A wrap in the same cycle as a wrap-clear write must still be recorded.
    if (wrap_set) wrap_d = 1'b1;
    if (read && address == 3'd4) shadow_d = cycle_cnt_q[63:32];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_cnt_q <= '0;
      shadow_q    <= '0;
      sec_q       <= '0;
      pre_q       <= '0;
      freeze_q    <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      shadow_q    <= shadow_d;
      sec_q       <= sec_d;
      pre_q       <= pre_d;
      freeze_q    <= freeze_d;
      wrap_q      <= wrap_d;
    end
  end

  assign word4          = cycle_cnt_q[31:0];
  assign word5          = shadow_q;
  assign word6          = {29'h0, wrap_q, freeze_q, 1'b0};
  assign word7          = sec_q;
  assign uptime_present = 1'b1;
`else
  assign word4          = '0;
  assign word5          = '0;
  assign word6          = '0;
  assign word7          = 32'(CLK_FREQ_HZ);
  assign uptime_present = 1'b0;
`endif

  always_comb begin
    rdata_d = rdata_q;
    if (read) begin
      unique case (address)
        3'd0:    rdata_d = SYSTEM_ID;
        3'd1:    rdata_d = TIMESTAMP;
        3'd2:    rdata_d = {VERSION, 8'h00, 7'h0, uptime_present};
        3'd3:    rdata_d = scratch_q;
        3'd4:    rdata_d = word4;
        3'd5:    rdata_d = word5;
        3'd6:    rdata_d = word6;
        3'd7:    rdata_d = word7;
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      scratch_q <= SCRATCH_RESET;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      scratch_q <= scratch_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= read;
    end
  end

  assign readdata      = rdata_q;
  assign readdatavalid = rvalid_q;

endmodule

// File: tb/tb_sysid_info_regs.sv
// Scoreboard bench for sysid_info_regs: expected read data queued at issue, checked on response.
module tb_sysid_info_regs;

  localparam logic [31:0] SysId = 32'h5AE2_A47C;
  localparam logic [31:0] Tstamp = 32'h1234_5678;
`ifdef SYSID_UPTIME_EN
  localparam logic [31:0] Word2 = 32'h0002_0001;
`else
  localparam logic [31:0] Word2 = 32'h0002_0000;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        readdatavalid;

  typedef struct {
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc_cnt = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  sysid_info_regs #(
    .SYSTEM_ID    (SysId),
    .TIMESTAMP    (Tstamp),
    .VERSION      (16'h0002),
    .CLK_FREQ_HZ  (4),
    .SCRATCH_RESET(32'h0000_0000)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .readdata     (readdata),
    .readdatavalid(readdatavalid)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One bus cycle; a read queues its expected response for the next cycle.
  task automatic cyc(input logic rd, input logic wr, input logic [2:0] a,
                     input logic [31:0] wd, input logic [31:0] exp);
    exp_t e;
    read = rd;
    write = wr;
    address = a;
    writedata = wd;
    if (rd && !reset) begin
      e.data = exp;
      e.due  = cyc_cnt + 1;
      sb_q.push_back(e);
    end
    @(posedge clock);
    #1;
    read = 1'b0;
    write = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
  endtask

  always @(negedge clock) begin
    if (readdatavalid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_valid", 32'(readdatavalid), 32'h0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("rdata", readdata, e.data);
        check_eq("latency", cyc_cnt, e.due);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    check_eq("rst_readdata", readdata, 32'h0);
    check_eq("rst_valid", 32'(readdatavalid), 32'h0);
    reset = 1'b0;

    cyc(1'b1, 1'b0, 3'd0, 32'h0, SysId);
    cyc(1'b1, 1'b0, 3'd1, 32'h0, Tstamp);
    cyc(1'b1, 1'b0, 3'd2, 32'h0, Word2);

    // Same-cycle read/write returns the pre-write value.
    cyc(1'b1, 1'b1, 3'd3, 32'hDEAD_BEEF, 32'h0000_0000);
    cyc(1'b1, 1'b0, 3'd3, 32'h0, 32'hDEAD_BEEF);
    idle(1);
    check_eq("hold_data", readdata, 32'hDEAD_BEEF);
    check_eq("hold_valid", 32'(readdatavalid), 32'h0);
    cyc(1'b0, 1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0);
    cyc(1'b1, 1'b0, 3'd0, 32'h0, SysId);

`ifdef SYSID_UPTIME_EN
    // High-word snapshot across a low-word carry.
    force dut.cycle_cnt_q = 64'h0000_0000_FFFF_FFFE;
    #1 release dut.cycle_cnt_q;
    cyc(1'b1, 1'b0, 3'd4, 32'h0, 32'hFFFF_FFFE);
    cyc(1'b1, 1'b0, 3'd5, 32'h0, 32'h0000_0000);
    cyc(1'b1, 1'b0, 3'd4, 32'h0, 32'h0000_0000);
    cyc(1'b1, 1'b0, 3'd5, 32'h0, 32'h0000_0001);

    // 64-bit wrap sets the sticky flag; bit2 write clears it.
    force dut.cycle_cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.cycle_cnt_q;
    idle(1);
    cyc(1'b1, 1'b0, 3'd4, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 3'd6, 32'h0, 32'h4);
    cyc(1'b0, 1'b1, 3'd6, 32'h4, 32'h0);
    cyc(1'b1, 1'b0, 3'd6, 32'h0, 32'h0);

    // Seconds at CLK_FREQ_HZ=4: clear, 12 cycles -> 3 seconds; then freeze.
    cyc(1'b0, 1'b1, 3'd6, 32'h1, 32'h0);
    idle(12);
    cyc(1'b1, 1'b0, 3'd7, 32'h0, 32'd3);
    cyc(1'b0, 1'b1, 3'd6, 32'h2, 32'h0);
    cyc(1'b1, 1'b0, 3'd4, 32'h0, 32'd14);
    cyc(1'b1, 1'b0, 3'd6, 32'h0, 32'h2);
    idle(20);
    cyc(1'b1, 1'b0, 3'd7, 32'h0, 32'd3);
    cyc(1'b1, 1'b0, 3'd4, 32'h0, 32'd14);
`else
    cyc(1'b1, 1'b0, 3'd4, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 3'd5, 32'h0, 32'h0);
    cyc(1'b0, 1'b1, 3'd6, 32'h7, 32'h0);
    cyc(1'b1, 1'b0, 3'd6, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 3'd7, 32'h0, 32'd4);
`endif

    // Back-to-back reads of all words; reset from the 5th cycle drops the rest.
    for (int i = 0; i < 8; i++) begin
      logic [31:0] e;
      unique case (i)
        0:       e = SysId;
        1:       e = Tstamp;
        2:       e = Word2;
        default: e = 32'hDEAD_BEEF;
      endcase
      if (i == 4) reset = 1'b1;
      cyc(1'b1, 1'b0, 3'(i), 32'h0, e);
      if (i >= 4) check_eq("rst_drop_valid", 32'(readdatavalid), 32'h0);
    end
    reset = 1'b0;
    cyc(1'b1, 1'b0, 3'd4, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 3'd5, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 3'd6, 32'h0, 32'h0);
`ifdef SYSID_UPTIME_EN
    cyc(1'b1, 1'b0, 3'd7, 32'h0, 32'h0);
`else
    cyc(1'b1, 1'b0, 3'd7, 32'h0, 32'd4);
`endif
    cyc(1'b1, 1'b0, 3'd3, 32'h0, 32'h0);
    idle(2);
    check_eq("sb_drained", sb_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sysid_info_regs.md
Name: sysid_info_regs

Overview:
- Parametrised successor to the fixed two-word system ID slave: an Avalon-MM read/write slave exposing an eight-word register file.
- Words: build identity (ID, timestamp, version, clock frequency), a scratch register, a 64-bit free-running cycle counter with coherent high-word snapshot, a seconds counter and a control/status word.
- Sits on the SoC interconnect beside the CPU. Software uses it for build checks, bus sanity tests and coarse timekeeping.

Parameters:
- SYSTEM_ID, 32'h0000_0000, value read at word 0.
- TIMESTAMP, 32'h0000_0000, build timestamp read at word 1.
- VERSION, 16'h0001, block/firmware version in word 2 [31:16].
- CLK_FREQ_HZ, 50000000, clock frequency; read at word 7 when the seconds counter is absent; also the prescaler terminal count. Must be ≥ 2.
- SCRATCH_RESET, 32'h0000_0000, reset value of the scratch register.

Ports:
- clock, input, 1, sole clock; all logic on the rising edge.
- reset, input, 1, synchronous, active-high.
- address, input, 3, word address.
- read, input, 1, read strobe, single cycle.
- write, input, 1, write strobe, single cycle.
- writedata, input, 32, write data.
- readdata, output, 32, registered read data.
- readdatavalid, output, 1, high for one cycle with valid readdata.

Behaviour:
- Reset (synchronous, active-high): readdata=0, readdatavalid=0, scratch=SCRATCH_RESET, cycle counter=0, high shadow=0, seconds=0, prescaler=0, freeze=0, wrap flag=0.
- Read latency is fixed at 1: read in cycle N gives readdatavalid=1 and readdata in cycle N+1. No waitrequest; back-to-back reads every cycle are supported. readdata holds its last value when readdatavalid=0.
- Address map:
  - 0: SYSTEM_ID (RO).
  - 1: TIMESTAMP (RO).
  - 2: {VERSION, 8'h00, 7'h0, uptime_present} (RO).
  - 3: scratch (RW, full 32 bits).
  - 4: cycle counter [31:0] (RO). The same read copies counter [63:32] into the high shadow.
  - 5: high shadow (RO). Returns the value latched by the last word-4 read.
  - 6: control/status.
    - Read: {29'h0, wrap, freeze, 1'b0}.
    - Write: bit0=1 clears cycle counter, seconds and prescaler (self-clearing, not stored). bit1 sets freeze. bit2=1 clears wrap.
  - 7: seconds counter (RO).
- Writes to RO addresses are ignored.
- Cycle counter:
  - Increments by 1 each cycle when freeze=0; holds when freeze=1.
  - At 64'hFFFF_FFFF_FFFF_FFFF it wraps to 0 and sets sticky wrap.
- Prescaler:
  - Counts 0..CLK_FREQ_HZ-1 when freeze=0.
  - At the terminal count it returns to 0 and the seconds counter increments.
  - The seconds counter wraps 32'hFFFF_FFFF→0 silently.
- Simultaneous events:
  - read and write in the same cycle: the write is performed, and the read returns the pre-write value.
  - Clear and increment in the same cycle: clear wins; the counter reads 0 on the following cycle.
  - Wrap and wrap-clear write in the same cycle: wrap set wins.
- The word-4 read value is the counter value in the read cycle. The shadow captures the matching upper half in that same cycle.
- Reset asserted while a read is outstanding: readdatavalid=0 next cycle and the response is dropped.
- Address bits are fully decoded; all 8 words are defined.

Optional Feature:
- Macro: SYSID_UPTIME_EN.
- Defined: cycle counter, shadow, prescaler, seconds, freeze and wrap are present as above, and word 2 bit0=1.
- Undefined:
  - Counter logic is removed.
  - Words 4, 5 read 0.
  - Word 6 reads 0; writes to word 6 are ignored.
  - Word 7 reads CLK_FREQ_HZ.
  - Word 2 bit0=0.
  - Read latency and the scratch register are unchanged.

Test Plan:
- Reset, then read words 0,1,2 with SYSTEM_ID=32'h5AE2_A47C, TIMESTAMP=32'h1234_5678, VERSION=16'h0002 -> readdatavalid exactly one cycle after each read; data 32'h5AE2_A47C, 32'h1234_5678, 32'h0002_0001.
- Write 32'hDEAD_BEEF to word 3, read word 3 in the same cycle, then the next cycle -> first read 32'h0000_0000 (SCRATCH_RESET), second 32'hDEAD_BEEF; write to word 0 leaves it reading SYSTEM_ID.
- Force the cycle counter to 64'h0000_0000_FFFF_FFFE, then read word 4 followed by word 5 -> word 4=32'hFFFF_FFFE, word 5=32'h0000_0000, not 1, despite the carry occurring in between.
- Force the counter to all-ones -> next cycle counter=0 and word 6 reads 32'h4. Write 32'h4 to word 6 -> word 6 reads 0.
- CLK_FREQ_HZ=4, run 12 cycles from clear -> word 7 reads 3. Write 32'h2 (freeze), wait 20 cycles -> word 7 still 3 and word 4 unchanged.
- Back-to-back reads of words 0..7 on 8 consecutive cycles, with reset asserted on the 5th -> 4 responses returned, readdatavalid=0 from the 6th cycle, all counters 0 after reset.
